// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed 4-digit 7-segment scan with blanking, frame snapshot and leading-zero suppression
module digit_scan_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [15:0] DIGITS_IN,
    input  logic [3:0]  DP_IN,
    input  logic        LZ_BLANK,
    output logic [1:0]  DIGIT_SEL,
    output logic        DIGIT_EN,
    output logic [3:0]  BCD_OUT,
    output logic        DP_OUT,
    output logic        FRAME_DONE
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [15:0]   snap_dig_q, snap_dig_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic          snap_lz_q, snap_lz_d;
    logic          digit_en_q, digit_en_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;
    logic          slot_end, wrap, load, lead, blanked;

    // state, slot counter, snapshot and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_q        <= '0;
            snap_dig_q   <= '0;
            snap_dp_q    <= '0;
            snap_lz_q    <= 1'b0;
            digit_en_q   <= 1'b0;
            bcd_q        <= '0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            snap_lz_q    <= snap_lz_d;
            digit_en_q   <= digit_en_d;
            bcd_q        <= bcd_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    // next state: blank phase ends after BLANK_CYCLES, slot ends at TICK_DIV-1, snapshot only at frame start
    always_comb begin
        slot_end     = state_q == SHOW && cnt_q == CNT_LAST;
        wrap         = slot_end && sel_q == 2'd3;
        load         = EN && (state_q == IDLE || wrap);
        state_d      = !EN ? IDLE :
                       state_q == IDLE  ? BLANK :
                       state_q == BLANK ? (cnt_q == CNT_SHOW ? SHOW : BLANK) :
                       (slot_end ? BLANK : SHOW);
        cnt_d        = (state_d == IDLE || state_q == IDLE || slot_end) ? '0 : cnt_q + CW'(1);
        sel_d        = (state_d == IDLE || state_q == IDLE) ? 2'd0 : slot_end ? sel_q + 2'd1 : sel_q;
        snap_dig_d   = load ? DIGITS_IN : snap_dig_q;
        snap_dp_d    = load ? DP_IN : snap_dp_q;
        snap_lz_d    = load ? LZ_BLANK : snap_lz_q;
        frame_done_d = EN && wrap;
    end

    // outputs for the coming cycle, derived from next state so they move on the same edge as DIGIT_SEL
    always_comb begin
        lead    = snap_lz_d;
        blanked = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            lead = lead && snap_dig_d[4*k +: 4] == 4'd0;
            if (sel_d == 2'(k)) blanked = lead;
        end
        digit_en_d = state_d == SHOW && !blanked;
        bcd_d      = state_d == IDLE ? 4'd0 : snap_dig_d[{sel_d, 2'b00} +: 4];
        dp_d       = snap_dp_d[sel_d] && digit_en_d;
    end

    assign DIGIT_SEL  = sel_q;
    assign DIGIT_EN   = digit_en_q;
    assign BCD_OUT    = bcd_q;
    assign DP_OUT     = dp_q;
    assign FRAME_DONE = frame_done_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: scoreboard bench driven by a time-since-enable reference model of the scan
module tb_digit_scan_ctrl;
    localparam int TD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * TD;

    logic        CLK = 1'b0;
    logic        RST, EN, LZ_BLANK, DP_OUT, DIGIT_EN, FRAME_DONE;
    logic [15:0] DIGITS_IN;
    logic [3:0]  DP_IN, BCD_OUT;
    logic [1:0]  DIGIT_SEL;

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic [3:0] bcd;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   started = 0;

    digit_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DIGITS_IN(DIGITS_IN), .DP_IN(DP_IN),
        .LZ_BLANK(LZ_BLANK), .DIGIT_SEL(DIGIT_SEL), .DIGIT_EN(DIGIT_EN),
        .BCD_OUT(BCD_OUT), .DP_OUT(DP_OUT), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    // reference model: t = cycles since scan (re)start; slot and phase follow by division
    int          t = -1;
    logic [15:0] sd;
    logic [3:0]  sdp;
    logic        slz;
    always @(posedge CLK) begin
        exp_t e;
        int   slot, pos;
        logic lit, bl;
        e = '0;
        if (RST || !EN) begin
            t = -1;
        end else begin
            if (t < 0 || t == FRAME - 1) begin
                e.fd = (t == FRAME - 1);
                t = 0;
                sd = DIGITS_IN;
                sdp = DP_IN;
                slz = LZ_BLANK;
            end else begin
                t++;
            end
            slot = t / TD;
            pos = t % TD;
            lit = pos >= BC;
            if (slz && slot > 0) begin
                bl = 1'b1;
                for (int j = slot; j < 4; j++) if (sd[4*j +: 4] != 4'd0) bl = 1'b0;
                if (bl) lit = 1'b0;
            end
            e.sel = slot[1:0];
            e.en = lit;
            e.bcd = sd[4*slot +: 4];
            e.dp = sdp[slot] && lit;
        end
        q.push_back(e);
        started = 1;
    end

    // monitor: compare DUT outputs against the scoreboard once per cycle
    always @(negedge CLK) begin
        exp_t e;
        if (started) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = q.pop_front();
                if ({DIGIT_SEL, DIGIT_EN, BCD_OUT, DP_OUT, FRAME_DONE} !== e) begin
                    bad++;
                    $display("FAIL scan at %0t: got sel=%0d en=%0b bcd=%0h dp=%0b fd=%0b, want sel=%0d en=%0b bcd=%0h dp=%0b fd=%0b",
                             $time, DIGIT_SEL, DIGIT_EN, BCD_OUT, DP_OUT, FRAME_DONE,
                             e.sel, e.en, e.bcd, e.dp, e.fd);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) d[4*i +: 4] = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
        return d;
    endfunction

    initial begin
        RST = 1'b1;
        EN = 1'b1;
        DIGITS_IN = 16'h1234;
        DP_IN = 4'b0100;
        LZ_BLANK = 1'b0;
        cycles(3);
        RST = 1'b0;
        cycles(4 * FRAME);
        cycles(TD + 3);
        DIGITS_IN = 16'h5678;
        cycles(2 * FRAME);
        LZ_BLANK = 1'b1;
        DIGITS_IN = 16'h0040;
        cycles(2 * FRAME);
        DIGITS_IN = 16'h0000;
        cycles(2 * FRAME);
        LZ_BLANK = 1'b0;
        DIGITS_IN = 16'h1234;
        cycles(FRAME + 2 * TD + BC + 2);
        EN = 1'b0;
        cycles(3);
        EN = 1'b1;
        cycles(FRAME + 9);
        RST = 1'b1;
        cycles(1);
        RST = 1'b0;
        DIGITS_IN = 16'h9876;
        DP_IN = 4'b1001;
        cycles(2 * FRAME);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                DIGITS_IN = rand_digits();
                DP_IN = 4'($urandom_range(0, 15));
                LZ_BLANK = 1'($urandom_range(0, 1));
            end
            if (EN) EN = $urandom_range(0, 149) != 0;
            else EN = $urandom_range(0, 2) == 0;
            RST = $urandom_range(0, 299) == 0;
            cycles(1);
        end
        RST = 1'b0;
        EN = 1'b1;
        cycles(FRAME + 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit 7-segment display of the timer. It steps a 2-bit digit index that drives the bcd_2bit_to_1hot decoder (digit anode select) and presents the matching BCD digit and decimal point to the segment path. It inserts anti-ghosting blanking at every digit change, snapshots the display value once per frame to avoid tearing, and optionally blanks leading zeros.

Parameters:
TICK_DIV, 100000, clock cycles per digit slot (blank + show); must be > BLANK_CYCLES.
BLANK_CYCLES, 16, cycles at start of each slot with DIGIT_EN low; must be >= 1.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  scan enable; 0 = display dark, controller idle.
DIGITS_IN  input  16  four BCD digits; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3.
DP_IN  input  4  decimal point per digit; bit k = digit k.
LZ_BLANK  input  1  1 = suppress leading zeros on digits 3..1.
DIGIT_SEL  output  2  current digit index; connects to decoder IN.
DIGIT_EN  output  1  1 = selected digit lit; gates decoder OUT to anodes.
BCD_OUT  output  4  snapshot BCD value of selected digit.
DP_OUT  output  1  snapshot DP of selected digit, ANDed with DIGIT_EN.
FRAME_DONE  output  1  one-cycle pulse at each frame wrap (digit 3 -> digit 0).

Behaviour:
- All outputs registered. Reset (overrides EN, any state): DIGIT_SEL=0, DIGIT_EN=0, BCD_OUT=0, DP_OUT=0, FRAME_DONE=0, slot counter CNT=0, snapshot regs=0, state IDLE.
- States: IDLE, BLANK, SHOW.
- IDLE: outputs as reset. On edge with EN=1: state BLANK, DIGIT_SEL=0, CNT=0, snapshot <= DIGITS_IN/DP_IN/LZ_BLANK.
- CNT counts 0..TICK_DIV-1 per slot, +1 each cycle in BLANK/SHOW.
- BLANK: DIGIT_EN=0. When CNT reaches BLANK_CYCLES (i.e., cycle index BLANK_CYCLES within slot) state SHOW.
- SHOW: DIGIT_EN=1 unless digit is leading-zero blanked. At CNT==TICK_DIV-1, next edge: CNT=0, state BLANK, DIGIT_SEL+1.
- Wrap: from DIGIT_SEL=3 at CNT==TICK_DIV-1, next edge DIGIT_SEL=0, snapshot reloaded from inputs, FRAME_DONE=1 for exactly that one cycle. Snapshot never changes mid-frame.
- Frame length = 4*TICK_DIV cycles; digit lit TICK_DIV-BLANK_CYCLES cycles per slot.
- BCD_OUT = snapshot digit[DIGIT_SEL], valid in all BLANK/SHOW cycles (updates same edge as DIGIT_SEL). DP_OUT = snapshot DP[DIGIT_SEL] & DIGIT_EN.
- Leading-zero blank: digit k (k in 3..1) blanked iff snapshot LZ_BLANK=1 and snapshot digits 3..k all equal 0. Digit 0 never blanked. Blanked digit: DIGIT_EN=0 for whole slot, DP_OUT=0; DIGIT_SEL still advances, slot timing unchanged.
- BCD values 10-15 passed through unchanged; no error handling.
- EN falls in any state: next edge returns to IDLE with all outputs at reset values; no FRAME_DONE. Re-enable restarts at digit 0 with fresh snapshot.
- Input changes while scanning take effect only at next frame wrap.

Test Plan:
(Bench params TICK_DIV=8, BLANK_CYCLES=2; frame = 32 cycles.)
1. RST=1 for 3 cycles with EN=1 -> all outputs 0; release with DIGITS_IN=16'h1234, DP_IN=4'b0100 -> DIGIT_SEL 0,1,2,3 each 8 cycles; per slot DIGIT_EN low 2 cycles then high 6; BCD_OUT 4,3,2,1; DP_OUT=1 only during lit cycles of digit 2.
2. Free-run 3 frames -> FRAME_DONE high exactly one cycle every 32 cycles, coincident with DIGIT_SEL 3->0.
3. Change DIGITS_IN to 16'h5678 mid-digit-1 -> BCD_OUT stays 3,2,1 for rest of frame; next frame shows 8,7,6,5.
4. LZ_BLANK=1, DIGITS_IN=16'h0040 -> digits 3,2 DIGIT_EN=0 whole slot; digit 1 (4) and digit 0 (0) lit. DIGITS_IN=16'h0000 -> only digit 0 lit showing 0.
5. Drop EN during SHOW of digit 2 -> next cycle all outputs 0, no FRAME_DONE; raise EN -> DIGIT_SEL=0 in BLANK, CNT restarts.
6. Assert RST mid-frame with EN=1 -> outputs 0 next cycle; after release, scan restarts at digit 0 with new snapshot.
